// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot sequencer:
// FSM state encoding, address stride and the word-index to byte-address helper.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } boot_state_e;

  localparam int unsigned ADDR_STRIDE = 4;

  // Byte address of a 32-bit instruction word
  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return 32'(32'(idx) * ADDR_STRIDE);
  endfunction

endpackage

// File: rtl/imem_boot_sequencer_hold_timer.sv
// Countdown that keeps the CPU in reset for HOLD cycles after the last load write.
// expired is asserted on the edge that ends the hold window.
module boot_hold_timer #(
  parameter int unsigned HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [7:0] count;

  // Reload on the last-word edge, then count down one per hold cycle
  always_ff @(posedge clk) begin
    if (rst)                        count <= 8'd0;
    else if (load)                  count <= 8'(HOLD);
    else if (tick && count != 8'd0) count <= count - 8'd1;
  end

  // Loaded value HOLD reaches 1 exactly HOLD-1 edges after the load edge
  assign expired = tick && (count == 8'd1);

endmodule

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer: streams a program into CPU instruction memory, then holds
// the CPU in reset for RESET_HOLD cycles before releasing it to run.
module imem_boot_sequencer
  import imem_boot_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned RESET_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        word_last,
  output logic        word_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_address,
  output logic [31:0] instruction_initialize_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        running,
  output logic        overflow,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] LAST_IDX = 16'(IMEM_WORDS - 1);

  boot_state_e state;
  logic        accept;
  logic        hold_load;
  logic        hold_tick;
  logic        hold_expired;

  // word_ready is only ever high in LOAD, so this is the acceptance handshake
  assign accept    = word_valid && word_ready;
  assign hold_load = accept && word_last;
  assign hold_tick = (state == ST_HOLD);

  boot_hold_timer #(.HOLD(RESET_HOLD)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .tick    (hold_tick),
    .expired (hold_expired)
  );

  // Sequencer FSM; every output is set alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      state                          <= ST_IDLE;
      word_ready                     <= 1'b0;
      initialize                     <= 1'b0;
      instruction_initialize_address <= 32'd0;
      instruction_initialize_data    <= 32'd0;
      cpu_rst                        <= 1'b1;
      busy                           <= 1'b0;
      running                        <= 1'b0;
      overflow                       <= 1'b0;
      words_loaded                   <= 16'd0;
    end else begin
      initialize <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (start) begin
            state        <= ST_LOAD;
            word_ready   <= 1'b1;
            cpu_rst      <= 1'b1;
            busy         <= 1'b1;
            running      <= 1'b0;
            overflow     <= 1'b0;
            words_loaded <= 16'd0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            initialize                     <= 1'b1;
            instruction_initialize_address <= word_addr(words_loaded);
            instruction_initialize_data    <= word_data;
            words_loaded                   <= words_loaded + 16'd1;
            if (word_last) begin
              state      <= ST_HOLD;
              word_ready <= 1'b0;
            end else if (words_loaded == LAST_IDX) begin
              // Memory is full but the stream is not done: keep the write, flag it
              state      <= ST_ERROR;
              word_ready <= 1'b0;
              busy       <= 1'b0;
              overflow   <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_expired) begin
            state   <= ST_RUN;
            cpu_rst <= 1'b0;
            busy    <= 1'b0;
            running <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          word_ready <= 1'b0;
          cpu_rst    <= 1'b1;
          busy       <= 1'b0;
          running    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_boot_sequencer.md
IMEM_BOOT_SEQUENCER -- requirements
Module: imem_boot_sequencer

Interface
REQ-001 Parameter IMEM_WORDS, default 64, instruction-memory capacity in 32-bit words.
REQ-002 Parameter RESET_HOLD, default 4, range 1..255: cycles the CPU reset is held after the last load write.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a program load.
REQ-006 word_valid  input  1  load-stream word is present.
REQ-007 word_data  input  32  instruction word.
REQ-008 word_last  input  1  marks the final word of the program.
REQ-009 word_ready  output  1  the block accepts a word this cycle.
REQ-010 initialize  output  1  instruction-memory write strobe to the CPU.
REQ-011 instruction_initialize_address  output  32  byte address of the write.
REQ-012 instruction_initialize_data  output  32  data of the write.
REQ-013 cpu_rst  output  1  reset to the CPU core.
REQ-014 busy  output  1  high in LOAD or HOLD.
REQ-015 running  output  1  high in RUN.
REQ-016 overflow  output  1  sticky error flag.
REQ-017 words_loaded  output  16  count of words accepted in the current or last load.

Function
REQ-018 States SHALL be IDLE, LOAD, HOLD, RUN and ERROR.
REQ-019 IDLE: cpu_rst=1, word_ready=0; start moves to LOAD, clears words_loaded and overflow.
REQ-020 LOAD: word_ready=1; a word is accepted on an edge where word_valid and word_ready are both 1.
REQ-021 A word accepted at edge k SHALL produce initialize=1 for exactly the cycle after edge k, with address=4*index and data=word_data; initialize=0 otherwise.
REQ-022 Accepted word indices SHALL start at 0 and increment by 1; words_loaded updates at the acceptance edge.
REQ-023 Accepting a word with word_last=1 SHALL move to HOLD.
REQ-024 Accepting index IMEM_WORDS-1 with word_last=0 SHALL still write it, set overflow, and move to ERROR; no address SHALL exceed 4*(IMEM_WORDS-1).
REQ-025 HOLD: word_ready=0, cpu_rst=1; when the last word is accepted at edge k, cpu_rst SHALL fall after edge k+RESET_HOLD and the state becomes RUN.
REQ-026 RUN: cpu_rst=0, running=1, word_ready=0.
REQ-027 ERROR: cpu_rst=1, word_ready=0, overflow=1; the state is left only by start or rst.
REQ-028 start in IDLE, RUN or ERROR SHALL enter LOAD on the next edge; cpu_rst SHALL be 1 from that edge.
REQ-029 start in LOAD or HOLD SHALL be ignored.
REQ-030 A word_valid with no start in IDLE, HOLD, RUN or ERROR SHALL be ignored and produce no write.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and clear all state, including a load or hold in progress.
REQ-032 After the reset edge: cpu_rst=1, initialize=0, word_ready=0, busy=0, running=0, overflow=0, words_loaded=0, and address/data=0.
REQ-033 rst SHALL take priority over start.

Structure
REQ-034 Package imem_boot_pkg SHALL hold the state encoding and the ADDR_STRIDE=4 constant.
REQ-035 The RESET_HOLD countdown SHALL be a sub-module named boot_hold_timer with load, tick and expired ports.
REQ-036 All outputs SHALL be registered.

Verification
REQ-037 Reset, start, words 0x20280005, 0x00021020, 0x0084402A with last on the third -> writes at 0, 4 and 8 one cycle after each acceptance; cpu_rst falls 4 cycles after the third acceptance; words_loaded=3.
REQ-038 word_valid toggling 1,0,1 in LOAD -> exactly two writes, at addresses 0 and 4, with no gap artefacts.
REQ-039 IMEM_WORDS=4, 5 words streamed with no last -> 4 writes at addresses 0..12, overflow=1, state ERROR, cpu_rst stays 1, and the 5th word is not accepted.
REQ-040 rst asserted during the second HOLD cycle -> IDLE, cpu_rst=1, no further initialize pulses.
REQ-041 start in RUN followed by a 1-word load with last -> cpu_rst rises on the next edge, one write at address 0, then a RUN release after RESET_HOLD cycles.
REQ-042 start pulsed mid-LOAD -> ignored; index continues without restarting at 0.
